// File: rtl/mru_stack.sv
// Move-to-front MRU stack of push-button IDs with per-button membership LEDs.
// Optional input debounce is enabled by defining MRU_DEBOUNCE_EN.
module mru_stack #(
  parameter int N_BTN      = 4,
  parameter int DEPTH      = 3,
  parameter int DEB_CYCLES = 16,
  localparam int IDW = $clog2(N_BTN + 1),
  localparam int CW  = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic [N_BTN-1:0]     btn,
  output logic [N_BTN-1:0]     led,
  output logic [IDW-1:0]       top_id,
  output logic [CW-1:0]        count,
  output logic                 busy,
  output logic                 evict,
  output logic [DEPTH*IDW-1:0] stack_flat
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  if (N_BTN < 1 || DEPTH < 1 || DEB_CYCLES < 1) begin : g_param_chk
    $error("mru_stack: N_BTN, DEPTH and DEB_CYCLES must all be >= 1");
  end

  typedef enum logic [1:0] {IDLE, SEARCH, UPDATE} state_t;

  state_t           state;
  logic [N_BTN-1:0] s1, s2, lvl, lvl_q, ev;
  logic [IDW-1:0]   stack  [DEPTH];
  logic [IDW-1:0]   nstack [DEPTH];
  logic [IDW-1:0]   id, win;
  logic             hit, s_hit, full;
  logic [PW-1:0]    pos, s_pos, span;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1    <= '0;
      s2    <= '0;
      lvl_q <= '0;
    end else begin
      s1    <= btn;
      s2    <= s1;
      lvl_q <= lvl;
    end
  end

`ifdef MRU_DEBOUNCE_EN
  localparam int DBW = $clog2(DEB_CYCLES + 1);
  logic [DBW-1:0] dcnt [N_BTN];

  // Level follows s2 only after DEB_CYCLES consecutive differing samples.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lvl <= '0;
      for (int unsigned i = 0; i < N_BTN; i++) dcnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < N_BTN; i++) begin
        if (s2[i] == lvl[i]) begin
          dcnt[i] <= '0;
        end else if (dcnt[i] == DBW'(DEB_CYCLES - 1)) begin
          lvl[i]  <= s2[i];
          dcnt[i] <= '0;
        end else begin
          dcnt[i] <= dcnt[i] + 1'b1;
        end
      end
    end
  end
`else
  always_comb lvl = s2;
`endif

  always_comb begin
    ev  = lvl & ~lvl_q;
    win = '0;
    for (int unsigned i = 0; i < N_BTN; i++)
      if (ev[i] && win == '0) win = IDW'(i + 1);
  end

  always_comb begin
    s_hit = 1'b0;
    s_pos = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (CW'(k) < count && stack[k] == id) begin
        s_hit = 1'b1;
        s_pos = PW'(k);
      end
    end
  end

  // A miss behaves like a hit at the bottom slot: everything shifts down.
  always_comb begin
    full = (count == CW'(DEPTH));
    span = hit ? pos : PW'(DEPTH - 1);
    for (int unsigned k = 0; k < DEPTH; k++) nstack[k] = stack[k];
    nstack[0] = id;
    for (int unsigned k = 1; k < DEPTH; k++)
      if (PW'(k) <= span) nstack[k] = stack[k-1];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      evict <= 1'b0;
      count <= '0;
      id    <= '0;
      hit   <= 1'b0;
      pos   <= '0;
      for (int unsigned k = 0; k < DEPTH; k++) stack[k] <= '0;
    end else if (clr) begin
      state <= IDLE;
      busy  <= 1'b0;
      evict <= 1'b0;
      count <= '0;
      id    <= '0;
      hit   <= 1'b0;
      pos   <= '0;
      for (int unsigned k = 0; k < DEPTH; k++) stack[k] <= '0;
    end else begin
      evict <= 1'b0;
      case (state)
        IDLE: begin
          if (|ev) begin
            id    <= win;
            busy  <= 1'b1;
            state <= SEARCH;
          end
        end
        SEARCH: begin
          hit   <= s_hit;
          pos   <= s_pos;
          state <= UPDATE;
        end
        UPDATE: begin
          for (int unsigned k = 0; k < DEPTH; k++) stack[k] <= nstack[k];
          if (!hit) begin
            if (full) evict <= 1'b1;
            else      count <= count + 1'b1;
          end
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    led        = '0;
    stack_flat = '0;
    top_id     = stack[0];
    for (int unsigned k = 0; k < DEPTH; k++) begin
      stack_flat[k*IDW +: IDW] = stack[k];
      for (int unsigned i = 0; i < N_BTN; i++)
        if (stack[k] == IDW'(i + 1)) led[i] = 1'b1;
    end
  end

endmodule

// File: tb/tb_mru_stack.sv
// Directed self-checking bench for mru_stack (N_BTN=4, DEPTH=3, DEB_CYCLES=16).
// Stack images are {entry2,entry1,entry0} packed 3 bits each.
module tb_mru_stack;

`ifdef MRU_DEBOUNCE_EN
  localparam int EXTRA = 16;
`else
  localparam int EXTRA = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       clr = 1'b0;
  logic [3:0] btn = '0;
  logic [3:0] led;
  logic [2:0] top_id;
  logic [1:0] count;
  logic       busy;
  logic       evict;
  logic [8:0] stack_flat;

  int checks = 0;
  int errors = 0;

  mru_stack #(.N_BTN(4), .DEPTH(3), .DEB_CYCLES(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .btn        (btn),
    .led        (led),
    .top_id     (top_id),
    .count      (count),
    .busy       (busy),
    .evict      (evict),
    .stack_flat (stack_flat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge with the pipeline idle; checks busy window and evict timing.
  task automatic press(input logic [3:0] mask, input logic ev_exp, input string tag);
    btn = mask;
    repeat (2 + EXTRA) @(negedge clk);
    chk({tag, "_busy_e2"}, busy, 0);
    @(negedge clk);
    chk({tag, "_busy_e3"}, busy, 1);
    @(negedge clk);
    chk({tag, "_busy_e4"}, busy, 1);
    chk({tag, "_evict_e4"}, evict, 0);
    @(negedge clk);
    chk({tag, "_busy_e5"}, busy, 0);
    chk({tag, "_evict_e5"}, evict, ev_exp);
    @(negedge clk);
    chk({tag, "_evict_e6"}, evict, 0);
    btn = '0;
    repeat (4 + EXTRA) @(negedge clk);
  endtask

  task automatic do_clr();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  initial begin
    // 1: reset held with toggling buttons
    for (int i = 0; i < 4; i++) begin
      btn = (i % 2 == 0) ? 4'b1111 : 4'b0101;
      @(negedge clk);
    end
    chk("rst_led", led, 0);
    chk("rst_count", count, 0);
    chk("rst_top", top_id, 0);
    chk("rst_flat", stack_flat, 0);
    chk("rst_evict", evict, 0);
    chk("rst_busy", busy, 0);
    btn = '0;
    @(negedge clk);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_count", count, 0);
    chk("post_rst_flat", stack_flat, 0);

    // 2: fill then evict
    press(4'b0001, 1'b0, "b1");
    chk("fill1_count", count, 1);
    chk("fill1_top", top_id, 1);
    press(4'b0010, 1'b0, "b2");
    press(4'b0100, 1'b0, "b3");
    chk("fill3_flat", stack_flat, 9'h053);
    chk("fill3_led", led, 4'b0111);
    chk("fill3_count", count, 3);
    chk("fill3_top", top_id, 3);
    press(4'b1000, 1'b1, "b4ev");
    chk("evict_flat", stack_flat, 9'h09C);
    chk("evict_led", led, 4'b1110);
    chk("evict_count", count, 3);

    // 3: move-to-front
    do_clr();
    chk("clr_flat", stack_flat, 0);
    chk("clr_count", count, 0);
    press(4'b0001, 1'b0, "m1");
    press(4'b0010, 1'b0, "m2");
    press(4'b0100, 1'b0, "m3");
    press(4'b0001, 1'b0, "mtf1");
    chk("mtf_flat", stack_flat, 9'h099);
    chk("mtf_count", count, 3);
    chk("mtf_top", top_id, 1);
    press(4'b0001, 1'b0, "mtf_top");
    chk("mtf_same_flat", stack_flat, 9'h099);
    press(4'b0100, 1'b0, "mtf_mid");
    chk("mtf_mid_flat", stack_flat, 9'h08B);
    chk("mtf_mid_led", led, 4'b0111);

    // 4: simultaneous edges, then an edge whose event lands in the busy window
    do_clr();
    press(4'b1010, 1'b0, "simul");
    chk("simul_flat", stack_flat, 9'h002);
    chk("simul_count", count, 1);
    chk("simul_led", led, 4'b0010);
    btn = 4'b0001;
    repeat (2) @(negedge clk);
    btn = 4'b0101;
    repeat (3 + EXTRA) @(negedge clk);
    chk("drop_busy_e5", busy, 0);
    chk("drop_flat", stack_flat, 9'h011);
    repeat (10 + EXTRA) @(negedge clk);
    chk("held_flat", stack_flat, 9'h011);
    chk("held_count", count, 2);
    chk("held_busy", busy, 0);
    btn = '0;
    repeat (4 + EXTRA) @(negedge clk);

    // 5: clr during SEARCH, then rst during UPDATE
    btn = 4'b1000;
    repeat (3 + EXTRA) @(negedge clk);
    chk("clr_mid_busy", busy, 1);
    do_clr();
    chk("clr_mid_flat", stack_flat, 0);
    chk("clr_mid_count", count, 0);
    chk("clr_mid_busy_low", busy, 0);
    repeat (8) @(negedge clk);
    chk("clr_after_flat", stack_flat, 0);
    chk("clr_after_led", led, 0);
    btn = '0;
    repeat (4 + EXTRA) @(negedge clk);

    btn = 4'b0010;
    repeat (4 + EXTRA) @(negedge clk);
    chk("rst_mid_busy", busy, 1);
    rst = 1'b0;
    #1;
    chk("rst_mid_busy_low", busy, 0);
    chk("rst_mid_flat", stack_flat, 0);
    chk("rst_mid_count", count, 0);
    chk("rst_mid_led", led, 0);
    chk("rst_mid_top", top_id, 0);
    btn = '0;
    @(negedge clk);
    chk("rst_hold_flat", stack_flat, 0);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    chk("rst_rel_count", count, 0);
    chk("rst_rel_busy", busy, 0);
    press(4'b0100, 1'b0, "after_rst");
    chk("after_rst_flat", stack_flat, 9'h003);
    chk("after_rst_count", count, 1);

`ifdef MRU_DEBOUNCE_EN
    // 6: short glitch ignored, long press accepted at edge 5+DEB_CYCLES
    btn = 4'b0001;
    repeat (5) @(negedge clk);
    btn = '0;
    repeat (40) @(negedge clk);
    chk("glitch_flat", stack_flat, 9'h003);
    chk("glitch_busy", busy, 0);
    press(4'b0001, 1'b0, "deb");
    chk("deb_flat", stack_flat, 9'h019);
    chk("deb_count", count, 2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
